// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS core: EX operand
// bypass selects, load-use interlock, multi-cycle divide occupancy, stall/flush.
module hazard_fwd_unit #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_wa,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic       ex_div_start,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_wa,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_wa,
  input  logic       wb_reg_write,
  input  logic       flush_all,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       div_busy,
  output logic       div_done
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_bad_div_cycles
    $error("hazard_fwd_unit: DIV_CYCLES must lie in 2..64");
  end
  if ((64'd1 << CNT_W) <= 64'(DIV_CYCLES)) begin : g_bad_cnt_w
    $error("hazard_fwd_unit: CNT_W too narrow for DIV_CYCLES");
  end

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic div_stall;
  logic load_use;

  // The youngest producer (MEM) wins over WB; $0 is hard-wired and never bypassed.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_dst,
    input logic       wb_we,
    input logic [4:0] wb_dst
  );
    if (mem_we && (mem_dst == src) && (mem_dst != 5'd0)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_dst == src) && (wb_dst != 5'd0)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign fwd_a_sel = fwd_select(ex_rs, mem_reg_write, mem_wa, wb_reg_write, wb_wa);
  assign fwd_b_sel = fwd_select(ex_rt, mem_reg_write, mem_wa, wb_reg_write, wb_wa);

  assign load_use = ex_is_load && ex_reg_write && (ex_wa != 5'd0) &&
                    ((ex_wa == id_rs) || (ex_wa == id_rt));

  // The start cycle already stalls, so the FSM spends DIV_CYCLES-1 cycles in BUSY.
  assign div_stall = busy_q || ((state_q == DIV_IDLE) && ex_div_start && !flush_all);

  assign div_busy = busy_q;
  assign div_done = done_q;

  // NOTE: reset is synchronous, so it is only seen at a rising edge; flush_all
  // shares the same path and aborts a divide without ever raising div_done.
  always_ff @(posedge clk) begin
    if (!resetn || flush_all) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (ex_div_start) begin
            state_q <= DIV_BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DIV_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    if (flush_all) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (div_stall) begin
      // EX is frozen, so only MEM receives bubbles while the divider runs.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sits directly upstream of the EX-stage 3:1 operand muxes and drives their 2-bit selects.
- Also detects load-use hazards and tracks multi-cycle divide occupancy with a state machine and countdown counter.
- Generates stall and flush controls for the IF, ID, EX and MEM pipeline registers.

Parameters:
- DIV_CYCLES, 32, total EX-stall cycles for one divide (legal range 2..64).
- CNT_W, 6, width of the divide countdown counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  input  1  core clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- id_rs, id_rt  input  5 each  source registers of the instruction in ID.
- ex_rs, ex_rt  input  5 each  source registers of the instruction in EX.
- ex_wa  input  5  destination of the instruction in EX.
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_is_load  input  1  EX instruction is a load.
- ex_div_start  input  1  EX instruction is DIV/DIVU.
- ex_branch_taken  input  1  branch or jump resolved taken in EX.
- mem_wa  input  5  destination of the instruction in MEM.
- mem_reg_write  input  1  MEM instruction writes the register file.
- wb_wa  input  5  destination of the instruction in WB.
- wb_reg_write  input  1  WB instruction writes the register file.
- flush_all  input  1  exception or eret flush.
- fwd_a_sel, fwd_b_sel  output  2 each  operand mux selects: 00 = register file, 01 = WB result, 10 = MEM ALU result; 11 is never driven.
- stall_if, stall_id, stall_ex  output  1 each  hold the corresponding pipeline register.
- flush_id, flush_ex, flush_mem  output  1 each  load a bubble into the corresponding pipeline register.
- div_busy  output  1  divide in progress (state BUSY).
- div_done  output  1  one-cycle strobe: divide result is valid this cycle.

Behaviour:
- Forwarding is combinational and evaluated separately for A (ex_rs) and B (ex_rt):
  - Select 10 if mem_reg_write and mem_wa equals the source and mem_wa != 0.
  - Otherwise select 01 if wb_reg_write and wb_wa equals the source and wb_wa != 0.
  - Otherwise select 00.
  - MEM has priority over WB. Register $0 is never forwarded.
- Load-use hazard: lu = ex_is_load & ex_reg_write & (ex_wa != 0) & (ex_wa == id_rs | ex_wa == id_rt). Response is stall_if = stall_id = 1 and flush_ex = 1, giving exactly 1 bubble. Load data then reaches EX via WB forwarding (01).
- Divide FSM, states IDLE, BUSY, DONE, with counter cnt[CNT_W-1:0]:
  - IDLE: if ex_div_start & !flush_all, go to BUSY with cnt = DIV_CYCLES-2. Assert div_stall in the start cycle.
  - BUSY: assert div_stall. If cnt == 0, go to DONE; otherwise cnt decrements.
  - DONE: div_done = 1 and div_stall = 0, so EX advances. ex_div_start is ignored in DONE. Always return to IDLE.
  - Total div_stall cycles = DIV_CYCLES (1 start cycle + DIV_CYCLES-1 BUSY cycles), followed by 1 DONE cycle.
  - Back-to-back divides: the second is accepted from IDLE on the cycle after DONE.
- div_stall response: stall_if = stall_id = stall_ex = 1 and flush_mem = 1. Under div_stall, flush_ex and flush_id are 0 (EX is frozen).
- Branch: ex_branch_taken gives flush_id = 1 and flush_ex = 1. The load-use stall is suppressed in the same cycle because the ID instruction is squashed.
- Priority: flush_all > div_stall > branch > load-use.
  - flush_all gives flush_id = flush_ex = flush_mem = 1 and all stalls 0.
  - flush_all forces the FSM to IDLE with cnt = 0, aborting any divide with no div_done.
- Reset: when resetn = 0 at a clock edge, the FSM goes to IDLE with cnt = 0. Reset mid-divide aborts it, with no div_done.
- Outputs are combinational from inputs and state. After reset, with all inputs 0, every output is 0.

Test Plan:
- Forwarding: ex_rs = 5 with mem_wa = 5, mem_reg_write = 1, and wb_wa = 5, wb_reg_write = 1 -> fwd_a_sel = 10. Drop mem_reg_write -> 01. Set ex_rs = 0 with both writers on $0 -> 00.
- Load-use: ex_is_load = 1, ex_wa = 8, id_rt = 8 -> stall_if = stall_id = flush_ex = 1 for exactly 1 cycle. Repeat with ex_wa = 0 -> no stall.
- Divide (DIV_CYCLES = 32): hold ex_div_start high -> stall_ex = flush_mem = 1 for exactly 32 cycles, div_busy for 31 of them, then 1 cycle of div_done = 1 with stalls 0, then the FSM accepts the next start.
- Abort: flush_all on the 10th BUSY cycle -> flush_id/ex/mem = 1, the FSM is in IDLE the next cycle, and div_done never pulses. Repeat using resetn = 0 -> same result.
- Simultaneous events: ex_branch_taken together with a load-use match -> flush_id = flush_ex = 1 and stall_id = 0. div_stall together with ex_branch_taken -> stalls only, flush_ex = 0.
- Reset: resetn = 0 for 2 cycles with random inputs, then inputs zeroed -> all outputs 0 and div_busy = 0.
